// File: rtl/panel_driver_if.sv
// Framebuffer read port between the panel driver (master) and the
// synchronous-read dual-bank pixel RAM (slave).
interface panel_driver_if #(
    parameter int PWM_WIDTH = 12
);
    logic [9:0]             fb_addr;
    logic [6*PWM_WIDTH-1:0] fb_data;

    modport master (output fb_addr, input  fb_data);
    modport slave  (input  fb_addr, output fb_data);
endinterface

// File: rtl/panel_driver.sv
// panel_driver: turns scan timing into panel pins. It reads the framebuffer,
// compares the six channel intensities against the PWM phase and drives
// RGB/CLK-enable/LAT/OE_n/ABC. It also owns tear-free front/back bank swapping.
module panel_driver #(
    parameter int PWM_WIDTH    = 12,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                 clk_in,
    input  logic                 reset,
    input  logic [2:0]           line,
    input  logic [5:0]           col,
    input  logic                 lat,
    input  logic [PWM_WIDTH-1:0] pwm,
    input  logic                 frame_clk,
    input  logic                 swap_req,
    output logic                 swap_ack,
    output logic                 front_bank,
    panel_driver_if.master       fb,
    output logic [5:0]           rgb,
    output logic                 pclk_en,
    output logic                 panel_lat,
    output logic                 oe_n,
    output logic [2:0]           abc
);

    localparam int              CNT_W      = 6;
    localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);

    logic                 swap_go;
    logic                 bank_eff;

    logic                 front_bank_q, front_bank_d;
    logic                 swap_ack_q,   swap_ack_d;

    logic                 v1_q,       v1_d;
    logic [PWM_WIDTH-1:0] pwm_s1_q,   pwm_s1_d;
    logic                 lat_s1_q,   lat_s1_d;
    logic [2:0]           line_s1_q,  line_s1_d;

    logic [5:0]           rgb_q,       rgb_d;
    logic                 pclk_en_q,   pclk_en_d;
    logic                 panel_lat_q, panel_lat_d;
    logic [2:0]           last_line_q, last_line_d;
    logic [2:0]           abc_q,       abc_d;
    logic [CNT_W-1:0]     blank_cnt_q, blank_cnt_d;
    logic                 shown_q,     shown_d;
    logic                 oe_n_q,      oe_n_d;

    // Bank selection: a swap taken on frame_clk already steers this cycle's read.
    always_comb begin
        swap_go      = swap_req & frame_clk;
        bank_eff     = front_bank_q ^ swap_go;
        fb.fb_addr   = {bank_eff, line, col};
        front_bank_d = bank_eff;
        swap_ack_d   = swap_go;
    end

    // Stage 1: timing info travels alongside its read so the phase matches the RAM data.
    always_comb begin
        v1_d      = 1'b1;
        pwm_s1_d  = pwm;
        lat_s1_d  = lat;
        line_s1_d = line;
    end

    // Stage 2: PWM compare, latch/row select and OE blanking for the next cycle.
    always_comb begin
        rgb_d = '0;
        for (int k = 0; k < 6; k++) begin
            if (v1_q) begin
                rgb_d[k] = (fb.fb_data[k*PWM_WIDTH +: PWM_WIDTH] > pwm_s1_q);
            end
        end

        pclk_en_d = v1_q;

        // The very first col 0 after reset has no previous line to latch.
        panel_lat_d = lat_s1_q & v1_q & pclk_en_q;

        last_line_d = v1_q ? line_s1_q : last_line_q;
        abc_d       = panel_lat_d ? last_line_q : abc_q;

        blank_cnt_d = blank_cnt_q;
        if (panel_lat_q) begin
            blank_cnt_d = BLANK_LOAD;
        end else if (blank_cnt_q != '0) begin
            blank_cnt_d = blank_cnt_q - CNT_W'(1);
        end

        shown_d = shown_q | panel_lat_q;
        oe_n_d  = ~shown_d | panel_lat_d | (blank_cnt_d != '0);
    end

    // All state registers; reset returns the panel to dark and the pipe to empty.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            front_bank_q <= 1'b0;
            swap_ack_q   <= 1'b0;
            v1_q         <= 1'b0;
            pwm_s1_q     <= '0;
            lat_s1_q     <= 1'b0;
            line_s1_q    <= '0;
            rgb_q        <= '0;
            pclk_en_q    <= 1'b0;
            panel_lat_q  <= 1'b0;
            last_line_q  <= '0;
            abc_q        <= '0;
            blank_cnt_q  <= '0;
            shown_q      <= 1'b0;
            oe_n_q       <= 1'b1;
        end else begin
            front_bank_q <= front_bank_d;
            swap_ack_q   <= swap_ack_d;
            v1_q         <= v1_d;
            pwm_s1_q     <= pwm_s1_d;
            lat_s1_q     <= lat_s1_d;
            line_s1_q    <= line_s1_d;
            rgb_q        <= rgb_d;
            pclk_en_q    <= pclk_en_d;
            panel_lat_q  <= panel_lat_d;
            last_line_q  <= last_line_d;
            abc_q        <= abc_d;
            blank_cnt_q  <= blank_cnt_d;
            shown_q      <= shown_d;
            oe_n_q       <= oe_n_d;
        end
    end

    assign front_bank = front_bank_q;
    assign swap_ack   = swap_ack_q;
    assign rgb        = rgb_q;
    assign pclk_en    = pclk_en_q;
    assign panel_lat  = panel_lat_q;
    assign oe_n       = oe_n_q;
    assign abc        = abc_q;

endmodule

// File: doc/panel_driver.md
Name: panel_driver

Overview:
- Downstream consumer of the scan timing generator. It sits between that generator, the dual-bank pixel framebuffer RAM and the LED panel pins.
- Each cycle it takes line/col/pwm/lat/frame_clk and issues a framebuffer read. It compares the returned 6 channel intensities against the PWM phase and drives the panel signals: RGB bits, shift clock enable, latch, OE/ and ABC.
- It also owns front/back bank selection, with tear-free swap only at frame boundaries.

Parameters:
PWM_WIDTH, 12, bits per colour channel; must equal the timing generator's PWM_WIDTH.
BLANK_CYCLES, 2, clk_in cycles OE/ is held high starting at each latch (range 1..63).

Ports:
clk_in  input  1  system clock, same clock as the timing generator
reset  input  1  asynchronous, active-high
line  input  3  logical scanline from timing
col  input  6  column from timing
lat  input  1  timing latch strobe, high when col==0
pwm  input  PWM_WIDTH  PWM phase from timing
frame_clk  input  1  start of PWM frame strobe from timing
swap_req  input  1  level; writer requests bank swap
swap_ack  output  1  one-cycle pulse; swap performed
front_bank  output  1  bank currently displayed
fb_addr  output  10  {bank_eff, line, col}; combinational to synchronous-read RAM
fb_data  input  6*PWM_WIDTH  {r0,g0,b0,r1,g1,b1}, MSB-first; valid one cycle after fb_addr
rgb  output  6  {r0,g0,b0,r1,g1,b1} shift data to panel
pclk_en  output  1  high when rgb holds a valid bit; pad DDR cell forms the panel CLK with its rising edge mid-cycle
panel_lat  output  1  panel LAT
oe_n  output  1  panel OE/, active-low
abc  output  3  panel row select

Behaviour:
- Reset (async, any time, including mid-line):
  - rgb=0, pclk_en=0, panel_lat=0, oe_n=1, abc=0, swap_ack=0, front_bank=0.
  - All pipeline registers clear; valid pipe is empty.
- Pipeline, for inputs sampled in cycle T:
  - fb_addr is presented in T.
  - Stage 1 (cycle T+1): registers pwm_d, lat_d, line_d, v1=1; fb_data is valid in this cycle.
  - Stage 2 (cycle T+2): rgb[i] <= (channel_i > pwm_d), unsigned, PWM_WIDTH bits. panel_lat <= lat_d; pclk_en <= v1.
  - Total latency is 2 cycles from timing inputs to panel outputs.
  - Channel value 0 is never on. Value 2^PWM_WIDTH-1 is on for every phase except pwm = all-ones.
- pclk_en:
  - 0 for the first 2 cycles after reset release.
  - 1 continuously thereafter, including on latch cycles.
- Latch:
  - panel_lat is high exactly in the cycle rgb carries col 0 of a new line.
  - The panel latches on panel_lat's rising edge, which comes before that cycle's mid-cycle CLK edge. The latched content is therefore the 64 bits of the previous line.
- ABC:
  - Register last_line <= line_d every valid stage-2 cycle.
  - In the panel_lat cycle, abc <= last_line, the line just latched.
  - abc changes only in cycles where oe_n=1.
- OE/:
  - Blank counter loads BLANK_CYCLES-1 in the panel_lat cycle. oe_n=1 in the panel_lat cycle and while the counter is nonzero; otherwise 0.
  - oe_n is held 1 from reset until the first panel_lat.
  - No display happens until the first line has been shifted and latched.
- Bank swap:
  - swap_go = swap_req & frame_clk.
  - bank_eff = front_bank ^ swap_go, so the first read of the new frame already addresses the new bank.
  - On swap_go, front_bank toggles at the end of that cycle, and swap_ack pulses high in the following cycle.
  - If swap_req is not high during frame_clk, there is no swap; the request waits for the next frame_clk.
  - If swap_req is still high at the next frame_clk, the bank toggles again. The writer must drop swap_req on swap_ack.
  - frame_clk without swap_req has no effect.
- Wrap-around:
  - col 63->0 and line 7->0 need no special handling.
  - pwm wrap is handled by pwm_d travelling with its address, so there is no mixed-phase line.

Test Plan:
- Reset release, timing counting from 0: panel_lat first high at cycle 2+64=66. oe_n=1 through cycle 66+BLANK_CYCLES-1, then 0. pclk_en=1 from cycle 2.
- fb_data r0=0x800, others 0, pwm sweeping: rgb[5]=1 exactly when pwm<0x800. Value 0 never sets a bit. Value 0xFFF is off only at pwm=0xFFF.
- Distinct data per {line,col}: rgb sequence matches addresses delayed 2 cycles. At the panel_lat following line 3, abc becomes 3, and oe_n=1 in that cycle.
- swap_req=1 held, frame_clk pulse: fb_addr[9]=1 in the frame_clk cycle, front_bank=1 the next cycle, swap_ack=1 for exactly one cycle. Drop swap_req: no further toggle at the next frame_clk.
- swap_req asserted mid-frame: no change until frame_clk; fb_addr[9] stays 0 until then.
- Reset asserted mid-line (col=30): all outputs return to reset values immediately. After release, behaviour is identical to the first scenario.
